// File: rtl/serv_dbg_pkg.sv
// Shared types for the serv debug controller: FSM states and host command codes.
package serv_dbg_pkg;

  typedef enum logic [2:0] {
    RUN,
    HALT_REQ,
    HALTED,
    RESUME,
    STEP,
    RESET
  } state_e;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_HALT   = 2'b00;
  localparam cmd_t CMD_RESUME = 2'b01;
  localparam cmd_t CMD_STEP   = 2'b10;
  localparam cmd_t CMD_RESET  = 2'b11;

endpackage

// File: rtl/serv_dbg_ctrl_if.sv
// Host-side bus of the debug controller: command handshake, status and shadow readback.
interface serv_dbg_ctrl_if;
  import serv_dbg_pkg::*;

  logic        i_cmd_valid;
  logic        o_cmd_ready;
  cmd_t        i_cmd;
  logic        o_halted;
  logic        o_err;
  logic [4:0]  i_rd_addr;
  logic [31:0] o_rd_data;

  // Host / bus bridge side
  modport master (
    output i_cmd_valid, i_cmd, i_rd_addr,
    input  o_cmd_ready, o_halted, o_err, o_rd_data
  );

  // Controller side
  modport slave (
    input  i_cmd_valid, i_cmd, i_rd_addr,
    output o_cmd_ready, o_halted, o_err, o_rd_data
  );

endinterface

// File: rtl/serv_dbg_shadow_rf.sv
// Shadow copy of x1..x31 assembled from the core's snooped RF byte stream.
// Only instantiated when SERV_DBG_SHADOW_EN is defined.
module serv_dbg_shadow_rf (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic [5:0]  i_waddr,
  input  logic        i_w1wren,
  input  logic        i_we,
  input  logic [7:0]  i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic [31:0] o_rd_data
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [1:31];
  logic [31:0] rd_q;
  logic        cap;

  // A GPR byte is captured only on write-port-1 strobes that target x0..x31
  assign cap = i_we & i_w1wren & ~i_waddr[5];

  // Byte position: advances on GPR bytes, realigns on any port-0 strobe
  always_comb begin
    cnt_d = cnt_q;
    if (i_we) begin
      if (!i_w1wren)
        cnt_d = '0;
      else if (!i_waddr[5])
        cnt_d = cnt_q + 2'd1;
    end
  end

  // Byte counter register
  always_ff @(posedge clk) begin
    if (i_rst || i_clr)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Shadow array: cleared on reset or controller request, x0 writes dropped
  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      for (int unsigned i = 1; i < 32; i++)
        mem_q[i] <= '0;
    end else if (cap && (i_waddr[4:0] != 5'd0)) begin
      mem_q[i_waddr[4:0]][{cnt_q, 3'b000} +: 8] <= i_wdata;
    end
  end

  // Registered read port; a same-cycle write is not forwarded
  always_ff @(posedge clk) begin
    if (i_rst)
      rd_q <= '0;
    else if (i_rd_addr == 5'd0)
      rd_q <= '0;
    else
      rd_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_q;

endmodule

// File: rtl/serv_dbg_ctrl.sv
// Host-side debug controller for a serv_rf_top core: turns halt/resume/step/reset
// commands into the core's debug handshake and optionally keeps a shadow of x1..x31.
// Optional feature macro: SERV_DBG_SHADOW_EN (shadow register file and capture logic).
module serv_dbg_ctrl
  import serv_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned RST_CYC = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  serv_dbg_ctrl_if.slave     bus,
  output logic               o_dbg_halt,
  output logic               o_dbg_reset,
  input  logic               i_dbg_process,
  input  logic               i_dbg_step,
  input  logic [5:0]         i_dbg_rf_waddr,
  input  logic               i_dbg_rf_w1wren,
  input  logic               i_dbg_rf_we,
  input  logic [7:0]         i_dbg_rf_wdata
);

  localparam int unsigned CNT_MAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           from_halted_q, from_halted_d;
  logic           halt_q, halt_d;
  logic           reset_q, reset_d;
  logic           halted_q, halted_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic           accept;
  logic           timeout;
  logic           shadow_clr;
  logic [31:0]    rd_data;

  assign accept  = bus.i_cmd_valid & ready_q;
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  // Next state, wait counter, sticky error and next registered outputs
  always_comb begin
    state_d       = state_q;
    from_halted_d = from_halted_q;
    err_d         = err_q;
    shadow_clr    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (accept) begin
          err_d = 1'b0;
          if (bus.i_cmd == CMD_HALT) begin
            state_d = HALT_REQ;
          end else if (bus.i_cmd == CMD_RESET) begin
            state_d       = RESET;
            from_halted_d = 1'b0;
          end
        end
      end
      HALT_REQ: begin
        if (i_dbg_process) begin
          state_d = HALTED;
        end else if (timeout) begin
          state_d = RUN;
          err_d   = 1'b1;
        end
      end
      HALTED: begin
        if (accept) begin
          err_d = 1'b0;
          if (bus.i_cmd == CMD_RESUME) begin
            state_d = RESUME;
          end else if (bus.i_cmd == CMD_STEP) begin
            state_d = STEP;
          end else if (bus.i_cmd == CMD_RESET) begin
            state_d       = RESET;
            from_halted_d = 1'b1;
          end
        end
      end
      RESUME: begin
        if (!i_dbg_process) begin
          state_d = RUN;
        end else if (timeout) begin
          state_d = HALTED;
          err_d   = 1'b1;
        end
      end
      STEP: begin
        if (i_dbg_step) begin
          state_d = HALTED;
        end else if (timeout) begin
          state_d = HALTED;
          err_d   = 1'b1;
        end
      end
      RESET: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          state_d    = from_halted_q ? HALTED : RUN;
          shadow_clr = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Counter only runs while waiting; any state change restarts it
    if ((state_d != state_q) || (state_d == RUN) || (state_d == HALTED))
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(1);

    // Outputs are decoded from the next state so they land in flops.
    // STEP releases halt only on its entry cycle; RESET holds whatever halt was.
    halt_d   = 1'b0;
    unique case (state_d)
      HALT_REQ, HALTED: halt_d = 1'b1;
      STEP:             halt_d = (state_q == STEP);
      RESET:            halt_d = halt_q;
      default:          halt_d = 1'b0;
    endcase
    reset_d  = (state_d == RESET);
    halted_d = (state_d == HALTED);
    ready_d  = (state_d == RUN) || (state_d == HALTED);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      from_halted_q <= 1'b0;
      halt_q        <= 1'b0;
      reset_q       <= 1'b0;
      halted_q      <= 1'b0;
      ready_q       <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      from_halted_q <= from_halted_d;
      halt_q        <= halt_d;
      reset_q       <= reset_d;
      halted_q      <= halted_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
    end
  end

  assign o_dbg_halt      = halt_q;
  assign o_dbg_reset     = reset_q;
  assign bus.o_halted    = halted_q;
  assign bus.o_cmd_ready = ready_q;
  assign bus.o_err       = err_q;
  assign bus.o_rd_data   = rd_data;

`ifdef SERV_DBG_SHADOW_EN
  serv_dbg_shadow_rf u_shadow (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_clr     (shadow_clr),
    .i_waddr   (i_dbg_rf_waddr),
    .i_w1wren  (i_dbg_rf_w1wren),
    .i_we      (i_dbg_rf_we),
    .i_wdata   (i_dbg_rf_wdata),
    .i_rd_addr (bus.i_rd_addr),
    .o_rd_data (rd_data)
  );
`else
  logic unused_snoop;
  assign unused_snoop = ^{shadow_clr, i_dbg_rf_waddr, i_dbg_rf_w1wren,
                          i_dbg_rf_we, i_dbg_rf_wdata, bus.i_rd_addr};
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
module tb_serv_dbg_ctrl;
  import serv_dbg_pkg::*;

  typedef enum int {S_HALT, S_RST, S_HALTED, S_READY, S_ERR, S_RDATA} sel_e;

  logic clk = 1'b0;
  logic rst;
  logic dbg_halt, dbg_reset;
  logic dbg_process, dbg_step;
  logic [5:0] rf_waddr;
  logic rf_w1wren, rf_we;
  logic [7:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  serv_dbg_ctrl_if bus ();

  serv_dbg_ctrl #(.TIMEOUT(16), .RST_CYC(4)) dut (
    .clk             (clk),
    .i_rst           (rst),
    .bus             (bus.slave),
    .o_dbg_halt      (dbg_halt),
    .o_dbg_reset     (dbg_reset),
    .i_dbg_process   (dbg_process),
    .i_dbg_step      (dbg_step),
    .i_dbg_rf_waddr  (rf_waddr),
    .i_dbg_rf_w1wren (rf_w1wren),
    .i_dbg_rf_we     (rf_we),
    .i_dbg_rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(sel_e s);
    case (s)
      S_HALT:   return {31'd0, dbg_halt};
      S_RST:    return {31'd0, dbg_reset};
      S_HALTED: return {31'd0, bus.o_halted};
      S_READY:  return {31'd0, bus.o_cmd_ready};
      S_ERR:    return {31'd0, bus.o_err};
      default:  return bus.o_rd_data;
    endcase
  endfunction

  function automatic logic [31:0] shexp(logic [31:0] v);
`ifdef SERV_DBG_SHADOW_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input sel_e s, input logic [31:0] v, input string n);
    logic [31:0] act;
    act = pick(s);
    checks++;
    if (act !== v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, v, $time);
    end
  endtask

  task automatic chk_ctl(input string n, input logic h, input logic r,
                         input logic hd, input logic rdy, input logic er);
    checks += 5;
    if (dbg_halt !== h) begin
      errors++;
      $display("FAIL %s.halt: got %b expected %b at %0t", n, dbg_halt, h, $time);
    end
    if (dbg_reset !== r) begin
      errors++;
      $display("FAIL %s.dbg_reset: got %b expected %b at %0t", n, dbg_reset, r, $time);
    end
    if (bus.o_halted !== hd) begin
      errors++;
      $display("FAIL %s.halted: got %b expected %b at %0t", n, bus.o_halted, hd, $time);
    end
    if (bus.o_cmd_ready !== rdy) begin
      errors++;
      $display("FAIL %s.ready: got %b expected %b at %0t", n, bus.o_cmd_ready, rdy, $time);
    end
    if (bus.o_err !== er) begin
      errors++;
      $display("FAIL %s.err: got %b expected %b at %0t", n, bus.o_err, er, $time);
    end
  endtask

  task automatic send(input cmd_t c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic snoop(input logic [5:0] a, input logic w1, input logic [7:0] d);
    rf_we     = 1'b1;
    rf_waddr  = a;
    rf_w1wren = w1;
    rf_wdata  = d;
    tick();
    rf_we     = 1'b0;
    rf_w1wren = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string n);
    bus.i_rd_addr = a;
    tick();
    chk(S_RDATA, shexp(v), n);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = CMD_HALT;
    bus.i_rd_addr = 5'd0;
    dbg_process = 1'b0;
    dbg_step = 1'b0;
    rf_waddr = '0;
    rf_w1wren = 1'b0;
    rf_we = 1'b0;
    rf_wdata = '0;
    tick();
    tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(S_RDATA, 32'd0, "reset.rdata");
    rst = 1'b0;

    send(CMD_HALT);
    chk_ctl("halt_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    dbg_process = 1'b1;
    chk(S_HALTED, 32'd0, "halt_req.wait");
    tick();
    chk_ctl("halted", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    send(CMD_RESUME);
    chk_ctl("resume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dbg_process = 1'b0;
    tick();
    chk_ctl("run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send(CMD_HALT);
    for (int i = 0; i < 15; i++) tick();
    chk_ctl("halt_to.before", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("halt_to", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    send(CMD_STEP);
    chk_ctl("run_step_noop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send(CMD_HALT);
    dbg_process = 1'b1;
    tick();
    chk_ctl("halted2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    snoop(6'd5, 1'b1, 8'hEF);
    snoop(6'd5, 1'b1, 8'hBE);
    snoop(6'd5, 1'b1, 8'hAD);
    snoop(6'd5, 1'b1, 8'hDE);
    rd(5'd5, 32'hDEADBEEF, "x5.first");
    snoop(6'd5, 1'b1, 8'h11);
    chk(S_RDATA, shexp(32'hDEADBEEF), "x5.prewrite");
    snoop(6'd5, 1'b1, 8'h22);
    snoop(6'd5, 1'b1, 8'h33);
    snoop(6'd5, 1'b1, 8'h44);
    chk(S_RDATA, shexp(32'hDE332211), "x5.partial");
    tick();
    chk(S_RDATA, shexp(32'h44332211), "x5.second");
    for (int i = 0; i < 4; i++) snoop(6'd0, 1'b1, 8'hA5);
    rd(5'd0, 32'd0, "x0.dropped");
    for (int i = 0; i < 4; i++) snoop(6'd33, 1'b1, 8'h5A);
    rd(5'd1, 32'd0, "csr.ignored");
    snoop(6'd6, 1'b1, 8'hAA);
    snoop(6'd6, 1'b0, 8'h00);
    snoop(6'd6, 1'b1, 8'h01);
    snoop(6'd6, 1'b1, 8'h02);
    snoop(6'd6, 1'b1, 8'h03);
    snoop(6'd6, 1'b1, 8'h04);
    rd(5'd6, 32'h04030201, "x6.realign");

    send(CMD_STEP);
    chk_ctl("step.entry", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("step.rehalt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    chk_ctl("step.done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    tick();
    chk_ctl("step.stray", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    send(CMD_RESET);
    chk_ctl("rst_h.0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_ctl($sformatf("rst_h.%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_ctl("rst_h.end", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(5'd5, 32'd0, "x5.cleared");
    rd(5'd6, 32'd0, "x6.cleared");

    send(CMD_RESUME);
    dbg_process = 1'b0;
    tick();
    send(CMD_RESET);
    chk_ctl("rst_r.0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_ctl("rst_r.3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("rst_r.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send(CMD_HALT);
    dbg_process = 1'b1;
    tick();
    send(CMD_STEP);
    for (int i = 0; i < 15; i++) tick();
    chk_ctl("step_to.before", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("step_to", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    send(CMD_STEP);
    chk(S_ERR, 32'd0, "step2.err_clr");
    tick();
    rst = 1'b1;
    tick();
    chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk(S_RDATA, 32'd0, "rst_mid.rdata");
    rst = 1'b0;
    dbg_process = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
